// File: rtl/mult_accumulator_if.sv
// ---------------------------------------------------------------------------
// mult_accumulator_if
//   Handshake bundle between the multiplier, the block accumulator and the
//   output formatter.
//
//   Parameters:
//     PROD_W - width of one unsigned product
//     ACC_W  - width of the block sum (PROD_W + guard bits)
//
//   Signals:
//     in_valid / in_ready / in_data           - product stream into the accumulator
//     out_valid / out_ready / out_data / out_ovf - block sum stream out of it
//
//   Modports:
//     slave  - the accumulator's view (consumes products, produces sums)
//     master - the surrounding logic's view (produces products, consumes sums)
// ---------------------------------------------------------------------------
interface mult_accumulator_if #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_ovf;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ovf
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ovf
    );
endinterface

// File: rtl/mult_accumulator.sv
// ---------------------------------------------------------------------------
// mult_accumulator
//   Sums each block of LEN unsigned products into a widened accumulator and
//   presents the block sum with a sticky overflow flag. One product is taken
//   per in_valid/in_ready handshake; the sum is held on the output until the
//   out_valid/out_ready handshake completes, and no products are taken
//   meanwhile.
//
//   Parameters:
//     PROD_W  - product width (multiplier output width)
//     GUARD_W - extra accumulator MSBs, ACC_W = PROD_W + GUARD_W
//     LEN     - products per block, 1..65535
//
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous active-high reset
//     bus   - mult_accumulator_if.slave (product input, block sum output)
//
//   Build option:
//     MULT_ACC_SAT_EN - when defined, the accumulator clamps to all-ones on a
//                       carry out instead of wrapping modulo 2^ACC_W.
// ---------------------------------------------------------------------------
module mult_accumulator #(
    parameter int PROD_W  = 32,
    parameter int GUARD_W = 8,
    parameter int LEN     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    mult_accumulator_if.slave     bus
);
    localparam int ACC_W = PROD_W + GUARD_W;
    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

    typedef enum logic {
        ST_ACC,
        ST_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W:0]     sum_ext;
    logic               carry;
    logic [ACC_W-1:0]   sum_acc;
    logic               accept;

    // The add is done one bit wider than the accumulator so the carry out of
    // the top accumulator bit is visible; that carry is the overflow event.
    // In the saturating build a carry pins the result at all-ones, and any
    // later nonzero add from all-ones carries again, so it stays pinned.
    always_comb begin
        sum_ext = {1'b0, acc_q} + {{(GUARD_W + 1){1'b0}}, bus.in_data};
        carry   = sum_ext[ACC_W];
`ifdef MULT_ACC_SAT_EN
        sum_acc = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        sum_acc = sum_ext[ACC_W-1:0];
`endif
    end

    // Next-state logic. In ACC each accepted product is added; the LEN-th one
    // moves the finished sum into the output register and clears the running
    // state so the next block starts clean the moment HOLD is released.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        accept     = bus.in_valid && (state_q == ST_ACC);

        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (count_q == LAST_IDX) begin
                        out_data_d = sum_acc;
                        out_ovf_d  = ovf_q | carry;
                        acc_d      = '0;
                        count_d    = '0;
                        ovf_d      = 1'b0;
                        state_d    = ST_HOLD;
                    end else begin
                        acc_d   = sum_acc;
                        count_d = count_q + CNT_W'(1);
                        ovf_d   = ovf_q | carry;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State register with synchronous reset; a reset at any point throws
    // away the partial or pending block sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    // Handshake outputs come straight from the state so the two are mutually
    // exclusive and no input can slip in while a sum is pending.
    always_comb begin
        bus.in_ready  = (state_q == ST_ACC);
        bus.out_valid = (state_q == ST_HOLD);
        bus.out_data  = out_data_q;
        bus.out_ovf   = out_ovf_q;
    end
endmodule
